vend_payment_ctrl: RTL

//   Sequential payment controller for the vending datapath. Latches an item

---
 rtl/vend_payment_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vend_payment_ctrl.sv
// ---------------------------------------------------------------------------
// vend_payment_ctrl
//   Payment controller for the vending datapath. When an item is selected it
//   latches the price, then adds up inserted coins until they cover that
//   price. It then requests a dispense with a valid/ready handshake and
//   finally returns any change. A customer cancel, a coin-inactivity timeout,
//   or a coin that would overflow the accumulator is also handled here.
//
// Parameters
//   PAID_W       accumulator / change width (must be >= PRICE_W)
//   PRICE_W      item price width
//   COIN_W       width of one coin value
//   TIMEOUT_CYC  idle cycles in COLLECT before an automatic cancel (>= 1)
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   select_valid    item selected; price is sampled in the same cycle
//   price           item price
//   coin_valid      coin inserted this cycle, with value coin_value
//   cancel          customer abort request
//   dispense_ready  dispenser accepts the dispense request
//   paid            accumulated payment (registered)
//   is_sufficient   paid covers the latched price (COLLECT/DISPENSE only)
//   dispense_valid  dispense request, held until dispense_ready
//   change_valid    one-cycle pulse, change_amount is valid
//   change_amount   change to return; holds until the next change phase
//   coin_reject     one-cycle pulse, coin refused and not added
//   timeout         one-cycle pulse, inactivity auto-cancel
//   busy            controller is not idle
// ---------------------------------------------------------------------------
module vend_payment_ctrl #(
  parameter int PAID_W      = 8,
  parameter int PRICE_W     = 6,
  parameter int COIN_W      = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               select_valid,
  input  logic [PRICE_W-1:0] price,
  input  logic               coin_valid,
  input  logic [COIN_W-1:0]  coin_value,
  input  logic               cancel,
  input  logic               dispense_ready,
  output logic [PAID_W-1:0]  paid,
  output logic               is_sufficient,
  output logic               dispense_valid,
  output logic               change_valid,
  output logic [PAID_W-1:0]  change_amount,
  output logic               coin_reject,
  output logic               timeout,
  output logic               busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  state_t            state_q, state_d;
  logic [PAID_W-1:0] paid_q, paid_d;
  logic [PAID_W-1:0] price_q, price_d;
  logic [PAID_W-1:0] change_q, change_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              dv_q, dv_d;
  logic              cv_q, cv_d;
  logic              rej_q, rej_d;
  logic              to_q, to_d;

  // One extra bit on the sum exposes accumulator overflow as a carry out.
  logic [PAID_W:0]   coin_sum;
  logic              coin_fits;
  logic              timer_hit;

  assign coin_sum  = {1'b0, paid_q} + (PAID_W+1)'(coin_value);
  assign coin_fits = ~coin_sum[PAID_W];
  // The timer holds the number of completed coin-free cycles; once that count
  // equals TIMEOUT_CYC the current cycle turns into an automatic cancel.
  assign timer_hit = (timer_q == TMR_W'(TIMEOUT_CYC));

  // State and output registers. Reset clears everything, whatever the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      paid_q   <= '0;
      price_q  <= '0;
      change_q <= '0;
      timer_q  <= '0;
      dv_q     <= 1'b0;
      cv_q     <= 1'b0;
      rej_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      paid_q   <= paid_d;
      price_q  <= price_d;
      change_q <= change_d;
      timer_q  <= timer_d;
      dv_q     <= dv_d;
      cv_q     <= cv_d;
      rej_q    <= rej_d;
      to_q     <= to_d;
    end
  end

  // Next-state and next-output logic. The pulse outputs default low so that
  // each one lasts a single cycle. In COLLECT, an abort (cancel or timeout)
  // wins over everything else, and any coin in that cycle is refused.
  always_comb begin
    state_d  = state_q;
    paid_d   = paid_q;
    price_d  = price_q;
    change_d = change_q;
    timer_d  = timer_q;
    dv_d     = dv_q;
    cv_d     = 1'b0;
    rej_d    = 1'b0;
    to_d     = 1'b0;

    case (state_q)
      IDLE: begin
        rej_d = coin_valid;
        if (select_valid) begin
          price_d = PAID_W'(price);
          paid_d  = '0;
          timer_d = '0;
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (cancel || timer_hit) begin
          to_d     = ~cancel;
          change_d = paid_q;
          cv_d     = 1'b1;
          rej_d    = coin_valid;
          state_d  = CHANGE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (coin_valid) begin
            if (coin_fits) begin
              paid_d  = coin_sum[PAID_W-1:0];
              timer_d = '0;
            end else begin
              rej_d = 1'b1;
            end
          end
          // A coin in the same cycle is still added; the excess becomes change.
          if (paid_q >= price_q) begin
            dv_d    = 1'b1;
            state_d = DISPENSE;
          end
        end
      end

      DISPENSE: begin
        rej_d = coin_valid;
        if (dispense_ready) begin
          dv_d     = 1'b0;
          change_d = paid_q - price_q;
          cv_d     = 1'b1;
          state_d  = CHANGE;
        end
      end

      CHANGE: begin
        rej_d   = coin_valid;
        paid_d  = '0;
        price_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign paid           = paid_q;
  assign dispense_valid = dv_q;
  assign change_valid   = cv_q;
  assign change_amount  = change_q;
  assign coin_reject    = rej_q;
  assign timeout        = to_q;
  assign busy           = (state_q != IDLE);
  assign is_sufficient  = ((state_q == COLLECT) || (state_q == DISPENSE)) &&
                          (paid_q >= price_q);

endmodule
